// File: rtl/fetch_responder.sv
// Purpose: instruction-fetch responder; owns the PC and turns a level fetch request into one memory read.
// Latency: fetch sampled T0 -> mem_read T1 -> (zero wait, rdvalid T2) capture T2 -> instr_valid T3.
// Backpressure: mem_wait holds the read in ISSUE with address stable; no timeout while awaiting rdvalid.
module fetch_responder #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    output logic              busy,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_wait,
    input  logic              mem_rdvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] PC_RESET   = ADDR_W'(RESET_PC);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend_vld;
    logic [ADDR_W-1:0] instr_pc_r;
    logic [DATA_W-1:0] instr_r;
    logic [ADDR_W-1:0] pc_new_al;

    // Redirect targets are always word aligned.
    assign pc_new_al = pc_new & ALIGN_MASK;

    // State register; reset aborts any in-flight read immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fetch is only looked at in IDLE and DONE, rdvalid only in WAIT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fetch)        state_nxt = ISSUE;
            ISSUE:   if (!mem_wait)    state_nxt = WAIT;
            WAIT:    if (mem_rdvalid)  state_nxt = DONE;
            DONE:    state_nxt = fetch ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // PC ownership: immediate load when idle, deferred redirect while a read is in flight,
    // and the post-fetch advance (pending redirect > live pc_load > increment) in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= PC_RESET;
            pend_pc  <= '0;
            pend_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pc_load) pc_r <= pc_new_al;
                end
                ISSUE, WAIT: begin
                    if (pc_load) begin
                        pend_pc  <= pc_new_al;
                        pend_vld <= 1'b1;
                    end
                end
                DONE: begin
                    if (pend_vld) begin
                        pc_r     <= pend_pc;
                        pend_vld <= 1'b0;
                    end else if (pc_load) begin
                        pc_r <= pc_new_al;
                    end else begin
                        pc_r <= pc_r + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture returned data together with the address it was read from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r    <= '0;
            instr_pc_r <= '0;
        end else if (state == WAIT && mem_rdvalid) begin
            instr_r    <= mem_rdata;
            instr_pc_r <= pc_r;
        end
    end

    // Outputs decode directly from state so they drop the instant reset asserts.
    assign mem_read    = (state == ISSUE);
    assign mem_addr    = mem_read ? pc_r : '0;
    assign busy        = (state == ISSUE) || (state == WAIT);
    assign instr_valid = (state == DONE);
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign pc          = pc_r;

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed scenarios followed by randomized traffic,
// all checked against a protocol-level reference model of the fetch transaction.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch;
    logic        pc_load;
    logic [31:0] pc_new;
    logic        busy;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_wait;
    logic        mem_rdvalid;
    logic [31:0] mem_rdata;

    fetch_responder #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .PC_INC   (4),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .busy        (busy),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc          (pc),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_wait    (mem_wait),
        .mem_rdvalid (mem_rdvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: where the current fetch transaction stands.
    // m_req  : read requested on the bus, not yet accepted
    // m_owed : read accepted, data still owed by memory
    // m_due  : data delivered, strobe expected this cycle
    bit          m_req, m_owed, m_due;
    logic [31:0] m_pc, m_pend, m_instr, m_ipc;
    bit          m_pend_v;
    int          strobes, rd_cycles, accepts;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req    = 0;
        m_owed   = 0;
        m_due    = 0;
        m_pc     = 32'h0;
        m_pend   = 32'h0;
        m_pend_v = 0;
        m_instr  = 32'h0;
        m_ipc    = 32'h0;
    endtask

    task automatic check_outputs();
        check("mem_read",    64'(mem_read),    64'(m_req));
        check("busy",        64'(busy),        64'(m_req | m_owed));
        check("instr_valid", 64'(instr_valid), 64'(m_due));
        check("pc",          64'(pc),          64'(m_pc));
        check("instr",       64'(instr),       64'(m_instr));
        check("instr_pc",    64'(instr_pc),    64'(m_ipc));
        if (m_req) check("mem_addr", 64'(mem_addr), 64'(m_pc));
        if (instr_valid === 1'b1) strobes++;
        if (mem_read === 1'b1) rd_cycles++;
    endtask

    // Advance one clock: apply the transaction rules to the inputs presented now,
    // then compare the DUT against the predicted post-edge view.
    task automatic tick();
        bit n_req  = 0;
        bit n_owed = 0;
        bit n_due  = 0;
        if (m_req) begin
            if (pc_load) begin m_pend = pc_new & ~32'h3; m_pend_v = 1; end
            if (!mem_wait) begin n_owed = 1; accepts++; end
            else n_req = 1;
        end else if (m_owed) begin
            if (pc_load) begin m_pend = pc_new & ~32'h3; m_pend_v = 1; end
            if (mem_rdvalid) begin
                m_instr = mem_rdata;
                m_ipc   = m_pc;
                n_due   = 1;
            end else n_owed = 1;
        end else if (m_due) begin
            if (m_pend_v) begin m_pc = m_pend; m_pend_v = 0; end
            else if (pc_load) m_pc = pc_new & ~32'h3;
            else m_pc = m_pc + 32'd4;
            n_req = fetch;
        end else begin
            if (pc_load) m_pc = pc_new & ~32'h3;
            n_req = fetch;
        end
        @(posedge clk);
        #1;
        m_req  = n_req;
        m_owed = n_owed;
        m_due  = n_due;
        check_outputs();
    endtask

    // Memory side of one read already in ISSUE: stall, accept, then return data after lat cycles.
    task automatic serve(input logic [31:0] data, input int waits, input int lat);
        for (int i = 0; i < waits; i++) begin
            mem_wait = 1'b1;
            tick();
        end
        mem_wait = 1'b0;
        tick();
        for (int i = 1; i < lat; i++) begin
            mem_rdvalid = 1'b0;
            tick();
        end
        mem_rdvalid = 1'b1;
        mem_rdata   = data;
        tick();
        mem_rdvalid = 1'b0;
        mem_rdata   = $urandom;
    endtask

    // Asynchronous reset from wherever the bench is; a stray rdvalid is presented across it.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst mem_read",    64'(mem_read),    64'h0);
        check("rst mem_addr",    64'(mem_addr),    64'h0);
        check("rst instr_valid", 64'(instr_valid), 64'h0);
        check("rst busy",        64'(busy),        64'h0);
        check("rst pc",          64'(pc),          64'h0);
        check("rst instr",       64'(instr),       64'h0);
        check("rst instr_pc",    64'(instr_pc),    64'h0);
        fetch       = 1'b0;
        pc_load     = 1'b0;
        pc_new      = 32'h0;
        mem_wait    = 1'b0;
        mem_rdvalid = 1'b1;
        mem_rdata   = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        mem_rdvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch = 1'b0; pc_load = 1'b0; pc_new = 32'h0;
        mem_wait = 1'b0; mem_rdvalid = 1'b0; mem_rdata = 32'h0;
        strobes = 0; rd_cycles = 0; accepts = 0;

        // 1: single fetch, zero wait, one-cycle read latency.
        do_reset();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("t1 mem_addr", 64'(mem_addr), 64'h0);
        serve(32'hDEAD_BEEF, 0, 1);
        check("t1 instr",    64'(instr),    64'hDEAD_BEEF);
        check("t1 instr_pc", 64'(instr_pc), 64'h0);
        check("t1 valid",    64'(instr_valid), 64'h1);
        tick();
        check("t1 pc", 64'(pc), 64'h4);
        check("t1 strobe len", 64'(instr_valid), 64'h0);

        // 2: fetch held high, three back-to-back reads.
        do_reset();
        strobes = 0;
        fetch = 1'b1;
        tick();
        check("t2 addr0", 64'(mem_addr), 64'h0);
        serve(32'h1111_0000, 0, 1);
        tick();
        check("t2 addr1", 64'(mem_addr), 64'h4);
        serve(32'h1111_0004, 0, 2);
        tick();
        check("t2 addr2", 64'(mem_addr), 64'h8);
        serve(32'h1111_0008, 0, 1);
        fetch = 1'b0;
        tick();
        check("t2 strobes", 64'(strobes), 64'd3);
        check("t2 pc", 64'(pc), 64'hC);

        // 3: five wait-state cycles in ISSUE; one read accepted.
        rd_cycles = 0;
        accepts   = 0;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        serve(32'h3333_3333, 5, 1);
        tick();
        check("t3 read cycles", 64'(rd_cycles), 64'd6);
        check("t3 accepts",     64'(accepts),   64'd1);

        // 4: redirect during WAIT of the read at 0x8, then unaligned load in IDLE.
        pc_load = 1'b1; pc_new = 32'h8; fetch = 1'b1;
        tick();
        pc_load = 1'b0; fetch = 1'b0;
        check("t4 addr 8", 64'(mem_addr), 64'h8);
        mem_wait = 1'b0;
        tick();
        pc_load = 1'b1; pc_new = 32'h100;
        tick();
        pc_load = 1'b0;
        mem_rdvalid = 1'b1; mem_rdata = 32'h4444_0008;
        tick();
        mem_rdvalid = 1'b0;
        check("t4 instr_pc", 64'(instr_pc), 64'h8);
        tick();
        check("t4 pc redirect", 64'(pc), 64'h100);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("t4 addr 100", 64'(mem_addr), 64'h100);
        serve(32'h4444_0100, 1, 1);
        tick();
        pc_load = 1'b1; pc_new = 32'h103;
        tick();
        pc_load = 1'b0;
        check("t4 pc aligned", 64'(pc), 64'h100);

        // 5: PC wrap at the top of the address space.
        pc_load = 1'b1; pc_new = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0; fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("t5 addr top", 64'(mem_addr), 64'hFFFF_FFFC);
        serve(32'h5555_5555, 0, 1);
        tick();
        check("t5 pc wrap", 64'(pc), 64'h0);

        // 6a: reset during ISSUE drops mem_read without waiting for a clock.
        fetch = 1'b1; mem_wait = 1'b1;
        tick();
        fetch = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6 read drop", 64'(mem_read), 64'h0);
        do_reset();

        // 6b: reset in WAIT, late rdvalid afterwards is ignored.
        fetch = 1'b1;
        tick();
        fetch = 1'b0; mem_wait = 1'b0;
        tick();
        #2;
        do_reset();
        mem_rdvalid = 1'b1; mem_rdata = 32'h6666_6666;
        tick();
        mem_rdvalid = 1'b0;
        tick();
        check("t6 no valid", 64'(instr_valid), 64'h0);
        check("t6 instr",    64'(instr),       64'h0);
        check("t6 pc",       64'(pc),          64'h0);

        // Randomized traffic: random fetch/redirect, wait states, latency and stray rdvalid.
        for (int c = 0; c < 600; c++) begin
            fetch   = ($urandom_range(0, 3) != 0);
            pc_load = ($urandom_range(0, 11) == 0);
            pc_new  = $urandom;
            if ($urandom_range(0, 5) == 0) pc_new = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            mem_wait    = m_req ? ($urandom_range(0, 2) == 0) : $urandom_range(0, 1) == 1;
            mem_rdvalid = m_owed ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            mem_rdata   = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
